rgb_pwm_gen: RTL and testbench

Generates the three PWM streams and enables that drive the on-chip RGB LED driver primitive.
It converts per-channel 8-bit duty values from the tk1 core into glitch-free PWM waveforms, using a programmable prescaler.
An optional blink FSM gates the outputs on and off in whole PWM periods.
It sits between the tk1 register file and the RGBA driver instance in the application FPGA.

---
 rtl/tk1_rgb_pkg.sv | 21 ++
 rtl/rgb_pwm_tick.sv | 45 ++++
 rtl/rgb_pwm_gen.sv | 172 +++++++++++++++++
 tb/tb_rgb_pwm_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tk1_rgb_pkg.sv
// Shared definitions for the tk1 RGB LED PWM generator: FSM encoding and width defaults.
package tk1_rgb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam int PWM_WIDTH_DEF      = 8;
    localparam int PRESCALE_WIDTH_DEF = 16;
    localparam int BLINK_WIDTH_DEF    = 8;

    // Full-scale duty: the counter tops out one below this, so this duty is always on.
    localparam int PWM_MAX = (1 << PWM_WIDTH_DEF) - 1;

    function automatic int ctr_top(input int width);
        return (1 << width) - 2;
    endfunction

endpackage

// File: rtl/rgb_pwm_tick.sv
// Prescaler and PWM period counter; both are held at zero while clear is high.
module rgb_pwm_tick
    import tk1_rgb_pkg::*;
#(
    parameter int PWM_WIDTH      = PWM_WIDTH_DEF,
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick,
    output logic [PWM_WIDTH-1:0]      pwm_ctr,
    output logic                      wrap
);

    localparam logic [PWM_WIDTH-1:0] CTR_TOP = PWM_WIDTH'(ctr_top(PWM_WIDTH));

    logic [PRESCALE_WIDTH-1:0] pre_cnt;

    // >= rather than == so that lowering prescale below the count wraps at once.
    assign tick = !clear && (pre_cnt >= prescale);
    assign wrap = tick && (pwm_ctr == CTR_TOP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_ctr <= '0;
        end else if (clear) begin
            pre_cnt <= '0;
            pwm_ctr <= '0;
        end else begin
            if (tick)
                pre_cnt <= '0;
            else
                pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);

            if (wrap)
                pwm_ctr <= '0;
            else if (tick)
                pwm_ctr <= pwm_ctr + PWM_WIDTH'(1);
        end
    end

endmodule

// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM generator for the RGBA LED driver, with shadowed duties and blink gating.
module rgb_pwm_gen
    import tk1_rgb_pkg::*;
#(
    parameter int PWM_WIDTH      = PWM_WIDTH_DEF,
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
    parameter int BLINK_WIDTH    = BLINK_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      duty_we,
    input  logic [PWM_WIDTH-1:0]      duty0,
    input  logic [PWM_WIDTH-1:0]      duty1,
    input  logic [PWM_WIDTH-1:0]      duty2,
    input  logic [BLINK_WIDTH-1:0]    blink_on,
    input  logic [BLINK_WIDTH-1:0]    blink_off,
    output logic                      rgb0_pwm,
    output logic                      rgb1_pwm,
    output logic                      rgb2_pwm,
    output logic                      led_en,
    output logic                      curr_en,
    output logic                      period_start
);

    state_t state, state_next;

    logic                   clear;
    logic                   tick;
    logic                   wrap;
    logic [PWM_WIDTH-1:0]   pwm_ctr;

    logic [PWM_WIDTH-1:0]   pending0, pending1, pending2;
    logic [PWM_WIDTH-1:0]   active0, active1, active2;

    logic [BLINK_WIDTH-1:0] blink_cnt;
    logic [BLINK_WIDTH:0]   blink_cnt_inc;
    logic [BLINK_WIDTH-1:0] on_len;
    logic                   on_done, off_done;
    logic                   blink_clr, blink_inc;

    logic                   raw0, raw1, raw2;

    assign clear = (state == IDLE) || !enable;

    rgb_pwm_tick #(
        .PWM_WIDTH      (PWM_WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .prescale (prescale),
        .tick     (tick),
        .pwm_ctr  (pwm_ctr),
        .wrap     (wrap)
    );

    // Duty shadowing: active values only change on a period boundary, or freely while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending0 <= '0;
            pending1 <= '0;
            pending2 <= '0;
            active0  <= '0;
            active1  <= '0;
            active2  <= '0;
        end else begin
            if (duty_we) begin
                pending0 <= duty0;
                pending1 <= duty1;
                pending2 <= duty2;
            end
            if (state == IDLE) begin
                active0 <= duty_we ? duty0 : pending0;
                active1 <= duty_we ? duty1 : pending1;
                active2 <= duty_we ? duty2 : pending2;
            end else if (wrap) begin
                active0 <= pending0;
                active1 <= pending1;
                active2 <= pending2;
            end
        end
    end

    // Blink phase length, counted in completed PWM periods.
    assign on_len        = (blink_on == '0) ? BLINK_WIDTH'(1) : blink_on;
    assign blink_cnt_inc = {1'b0, blink_cnt} + (BLINK_WIDTH + 1)'(1);
    assign on_done       = blink_cnt_inc >= {1'b0, on_len};
    assign off_done      = blink_cnt_inc >= {1'b0, blink_off};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            blink_cnt <= '0;
        end else begin
            state <= state_next;
            if (blink_clr)
                blink_cnt <= '0;
            else if (blink_inc)
                blink_cnt <= blink_cnt + BLINK_WIDTH'(1);
        end
    end

    always_comb begin
        state_next = state;
        blink_clr  = 1'b0;
        blink_inc  = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            blink_clr  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_next = ON;
                    blink_clr  = 1'b1;
                end
                ON: begin
                    // With blink_off == 0 the counter is parked so it never overflows.
                    if (wrap && (blink_off != '0)) begin
                        if (on_done) begin
                            state_next = OFF;
                            blink_clr  = 1'b1;
                        end else begin
                            blink_inc = 1'b1;
                        end
                    end
                end
                OFF: begin
                    if (wrap) begin
                        if (off_done) begin
                            state_next = ON;
                            blink_clr  = 1'b1;
                        end else begin
                            blink_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    blink_clr  = 1'b1;
                end
            endcase
        end
    end

    // Stage 0: compare against the active duties.
    assign raw0 = pwm_ctr < active0;
    assign raw1 = pwm_ctr < active1;
    assign raw2 = pwm_ctr < active2;

    // Stage 1: registered outputs; enable is folded in so a drop is seen one clock later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb0_pwm     <= 1'b0;
            rgb1_pwm     <= 1'b0;
            rgb2_pwm     <= 1'b0;
            led_en       <= 1'b0;
            curr_en      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            rgb0_pwm     <= raw0 && (state == ON) && enable;
            rgb1_pwm     <= raw1 && (state == ON) && enable;
            rgb2_pwm     <= raw2 && (state == ON) && enable;
            led_en       <= (state != IDLE) && enable;
            curr_en      <= (state != IDLE) && enable;
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Directed bench for rgb_pwm_gen: duty counts per period, shadowing, blink, enable and reset.
module tb_rgb_pwm_gen;
    import tk1_rgb_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] prescale;
    logic        duty_we;
    logic [7:0]  duty0, duty1, duty2;
    logic [7:0]  blink_on, blink_off;
    logic        rgb0_pwm, rgb1_pwm, rgb2_pwm;
    logic        led_en, curr_en, period_start;

    int n_cmp;
    int n_err;

    rgb_pwm_gen dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .prescale     (prescale),
        .duty_we      (duty_we),
        .duty0        (duty0),
        .duty1        (duty1),
        .duty2        (duty2),
        .blink_on     (blink_on),
        .blink_off    (blink_off),
        .rgb0_pwm     (rgb0_pwm),
        .rgb1_pwm     (rgb1_pwm),
        .rgb2_pwm     (rgb2_pwm),
        .led_en       (led_en),
        .curr_en      (curr_en),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Negedges until period_start is seen; -1 if the budget runs out.
    task automatic wait_ps(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_win(input int len, output int h0, output int h1, output int h2,
                           output int hp, output int hl);
        h0 = 0; h1 = 0; h2 = 0; hp = 0; hl = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            h0 += int'(rgb0_pwm === 1'b1);
            h1 += int'(rgb1_pwm === 1'b1);
            h2 += int'(rgb2_pwm === 1'b1);
            hp += int'(period_start === 1'b1);
            hl += int'(led_en === 1'b1);
        end
    endtask

    task automatic load_duty(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        duty0 = d0; duty1 = d1; duty2 = d2;
        duty_we = 1'b1;
        @(negedge clk);
        duty_we = 1'b0;
    endtask

    initial begin
        int h0, h1, h2, hp, hl, n;
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0; enable = 1'b0; prescale = 16'd0; duty_we = 1'b0;
        duty0 = 8'd0; duty1 = 8'd0; duty2 = 8'd0; blink_on = 8'd0; blink_off = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {26'd0, rgb0_pwm, rgb1_pwm, rgb2_pwm, led_en, curr_en, period_start}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Duties 0/128/254 at prescale 0
        load_duty(8'd0, 8'd128, 8'd254);
        enable = 1'b1;
        @(negedge clk);
        check("led_en_1clk", led_en, 1'b0);
        @(negedge clk);
        check("led_en_2clk", led_en, 1'b1);
        check("curr_en_2clk", curr_en, 1'b1);
        run_win(255, h0, h1, h2, hp, hl);
        check("t1_rgb0_high", h0, 0);
        check("t1_rgb1_high", h1, 128);
        check("t1_rgb2_high", h2, 254);
        check("t1_period_starts", hp, 1);
        check("t1_led_en_high", hl, 255);

        // Full-scale duty at prescale 3
        enable = 1'b0;
        prescale = 16'd3;
        @(negedge clk);
        load_duty(8'd255, 8'd128, 8'd254);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        run_win(2040, h0, h1, h2, hp, hl);
        check("t2_rgb0_const1", h0, 2040);
        check("t2_period_starts", hp, 2);
        wait_ps(1100, n);
        check("t2_ps_found", n > 0, 1'b1);
        wait_ps(1100, n);
        check("t2_ps_spacing", n, 1020);

        // Duty change mid-period is deferred to the next period
        enable = 1'b0;
        prescale = 16'd0;
        @(negedge clk);
        load_duty(8'd64, 8'd0, 8'd0);
        enable = 1'b1;
        wait_ps(600, n);
        check("t3_ps_found", n > 0, 1'b1);
        h0 = 0;
        for (int i = 0; i < 255; i++) begin
            if (i == 100) begin
                duty0 = 8'd200;
                duty_we = 1'b1;
            end else begin
                duty_we = 1'b0;
            end
            @(negedge clk);
            h0 += int'(rgb0_pwm === 1'b1);
        end
        duty_we = 1'b0;
        check("t3_old_period", h0, 64);
        run_win(255, h0, h1, h2, hp, hl);
        check("t3_new_period", h0, 200);
        check("t3_new_period_ps", hp, 1);

        // Blink 2 on / 1 off
        enable = 1'b0;
        blink_on = 8'd2;
        blink_off = 8'd1;
        @(negedge clk);
        load_duty(8'd100, 8'd0, 8'd0);
        enable = 1'b1;
        wait_ps(600, n);
        check("t4_ps_found", n, 256);
        run_win(255, h0, h1, h2, hp, hl);
        check("t4_on_p2", h0, 100);
        check("t4_led_p2", hl, 255);
        run_win(255, h0, h1, h2, hp, hl);
        check("t4_off_p3", h0, 0);
        check("t4_led_p3", hl, 255);
        run_win(255, h0, h1, h2, hp, hl);
        check("t4_on_p4", h0, 100);
        run_win(255, h0, h1, h2, hp, hl);
        check("t4_on_p5", h0, 100);
        run_win(255, h0, h1, h2, hp, hl);
        check("t4_off_p6", h0, 0);

        // Enable dropped mid-ON, then re-enabled with retained duties
        enable = 1'b0;
        blink_on = 8'd0;
        blink_off = 8'd0;
        @(negedge clk);
        load_duty(8'd255, 8'd128, 8'd254);
        enable = 1'b1;
        repeat (300) @(negedge clk);
        check("t5_rgb0_running", rgb0_pwm, 1'b1);
        check("t5_led_running", led_en, 1'b1);
        enable = 1'b0;
        duty0 = 8'd7; duty1 = 8'd7; duty2 = 8'd7;
        @(negedge clk);
        check("t5_off_outputs", {27'd0, rgb0_pwm, rgb1_pwm, rgb2_pwm, led_en, curr_en}, 32'd0);
        enable = 1'b1;
        wait_ps(600, n);
        check("t5_restart_ps", n, 256);
        run_win(255, h0, h1, h2, hp, hl);
        check("t5_rgb0_retained", h0, 255);
        check("t5_rgb1_retained", h1, 128);
        check("t5_rgb2_retained", h2, 254);

        // Asynchronous reset between clock edges
        @(negedge clk);
        check("t6_rgb0_before", rgb0_pwm, 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        enable = 1'b0;
        #1;
        check("t6_async_outputs", {27'd0, rgb0_pwm, rgb1_pwm, rgb2_pwm, led_en, curr_en}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_win(20, h0, h1, h2, hp, hl);
        check("t6_idle_led", hl, 0);
        check("t6_idle_ps", hp, 0);
        enable = 1'b1;
        wait_ps(600, n);
        check("t6_restart_ps", n, 256);
        run_win(255, h0, h1, h2, hp, hl);
        check("t6_duty_cleared", h0 + h1 + h2, 0);
        check("t6_led_on", hl, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
